// File: rtl/neuron_pkg.sv
// ----------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the neuron datapath stages.
//   - SM_W / MAG_MAX : sign-magnitude term format (bit7 = sign, bits6:0 = mag)
//   - state_t        : sequencing states used by neuron_accumulator
//   - sm_to_tc       : sign-magnitude -> two's complement, wrapped to accW bits
//   - tc_to_sm_sat   : two's complement -> saturated sign-magnitude {sat, data}
// ----------------------------------------------------------------------------
package neuron_pkg;

   localparam int SM_W = 8;
   localparam logic [SM_W-2:0] MAG_MAX = 7'd127;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Converts a sign-magnitude term to two's complement. The result is
   // returned in 32 bits but already wrapped/sign-extended from accW bits,
   // so a caller may truncate it to accW without changing its value.
   // Negative zero (8'h80) naturally comes out as 0 because -0 == 0.
   function automatic logic signed [31:0] sm_to_tc(input logic [SM_W-1:0] sm,
                                                   input int accW);
      logic signed [31:0] mag;
      logic signed [31:0] val;
      int                 sh;
      mag = {25'd0, sm[SM_W-2:0]};
      val = sm[SM_W-1] ? -mag : mag;
      if (accW >= 32 || accW < 1) begin
         return val;
      end
      sh = 32 - accW;
      return (val <<< sh) >>> sh;
   endfunction

   // Clamps a two's-complement value into the symmetric sign-magnitude range
   // [-127, +127]. Returns {sat, data}. Zero is always encoded as 8'h00.
   function automatic logic [SM_W:0] tc_to_sm_sat(input logic signed [31:0] v);
      logic signed [31:0] absV;
      if (v > 32'sd127) begin
         return {1'b1, 1'b0, MAG_MAX};
      end
      if (v < -32'sd127) begin
         return {1'b1, 1'b1, MAG_MAX};
      end
      if (v < 0) begin
         absV = -v;
         return {1'b0, 1'b1, absV[SM_W-2:0]};
      end
      return {1'b0, 1'b0, v[SM_W-2:0]};
   endfunction

endpackage

// File: rtl/neuron_accumulator_sm_sat_convert.sv
// ----------------------------------------------------------------------------
// sm_sat_convert
// Combinational conversion of the wide two's-complement accumulator into the
// 8-bit saturated sign-magnitude result.
// Ports:
//   acc_i  : accumulator value, ACC_W-bit two's complement
//   data_o : sign-magnitude result (8'h7F / 8'hFF when clamped, never 8'h80)
//   sat_o  : high when acc_i lay outside [-127, +127]
// ----------------------------------------------------------------------------
module sm_sat_convert
   import neuron_pkg::*;
#(
   parameter int ACC_W = 12
) (
   input  logic signed [ACC_W-1:0] acc_i,
   output logic [SM_W-1:0]         data_o,
   output logic                    sat_o
);

   logic signed [31:0] accExt;
   logic [SM_W:0]      result;

   // Sign-extend to the function's fixed 32-bit working width.
   assign accExt = 32'(acc_i);
   assign result = tc_to_sm_sat(accExt);
   assign sat_o  = result[SM_W];
   assign data_o = result[SM_W-1:0];

endmodule

// File: rtl/neuron_accumulator.sv
// ----------------------------------------------------------------------------
// neuron_accumulator
// Sums exactly N_TERMS sign-magnitude terms per evaluation in a wide
// two's-complement accumulator and returns one saturated sign-magnitude
// result through a valid/ready output.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : one-cycle pulse beginning an evaluation, honoured only in IDLE
//   in_valid  : in_data carries a term
//   in_ready  : a term is accepted this cycle (high in ACCUM)
//   in_data   : term, bit7 = sign, bits6:0 = magnitude
//   out_valid : result available (high in DONE)
//   out_ready : downstream accepts the result
//   out_data  : saturated sign-magnitude result
//   out_sat   : result was clamped, qualified by out_valid
//   busy      : high in ACCUM and DONE
// ----------------------------------------------------------------------------
module neuron_accumulator
   import neuron_pkg::*;
#(
   parameter int N_TERMS = 3,
   parameter int ACC_W   = 12,
   parameter int CNT_W   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SM_W-1:0] in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SM_W-1:0] out_data,
   output logic            out_sat,
   output logic            busy
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

   state_t                   state_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  acc_d;
   logic signed [ACC_W-1:0]  term_tc;
   logic [CNT_W-1:0]         cnt_q;
   logic [CNT_W-1:0]         cnt_d;
   logic                     in_ready_q;
   logic                     out_valid_q;
   logic [SM_W-1:0]          out_data_q;
   logic                     out_sat_q;
   logic                     busy_q;
   logic [SM_W-1:0]          res_data;
   logic                     res_sat;
   logic                     accept;
   logic                     last_term;

   // The ACC_W sizing rule guarantees the running sum never overflows, so the
   // truncation of the 32-bit conversion result is value-preserving.
   assign term_tc   = ACC_W'(sm_to_tc(in_data, ACC_W));
   assign acc_d     = acc_q + term_tc;
   assign cnt_d     = cnt_q + CNT_W'(1);
   assign accept    = in_valid && in_ready_q;
   assign last_term = (cnt_q == LAST_CNT);

   // The result is converted from acc_d rather than acc_q so that out_data is
   // registered on the same edge that accepts the final term; out_valid then
   // appears one cycle after that accept.
   sm_sat_convert #(
      .ACC_W(ACC_W)
   ) u_conv (
      .acc_i (acc_d),
      .data_o(res_data),
      .sat_o (res_sat)
   );

   // Single sequencing process. All outputs are registers updated together
   // with the state so they change only on state transitions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= ACCUM;
               end
            end

            ACCUM: begin
               // Cycles without in_valid leave acc and cnt untouched; start is
               // deliberately ignored here.
               if (accept) begin
                  acc_q <= acc_d;
                  if (last_term) begin
                     out_data_q  <= res_data;
                     out_sat_q   <= res_sat;
                     out_valid_q <= 1'b1;
                     in_ready_q  <= 1'b0;
                     state_q     <= DONE;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
            end

            DONE: begin
               // out_data/out_sat stay frozen until the handshake. A start
               // arriving in the handshake cycle is lost because the state is
               // still DONE.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end

            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// ----------------------------------------------------------------------------
// tb_neuron_accumulator
// Directed-vector bench for neuron_accumulator. Expected results are queued
// when an evaluation is launched and a monitor pops them on each output
// handshake.
// ----------------------------------------------------------------------------
module tb_neuron_accumulator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_sat;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   logic [8:0] expQ[$];

   neuron_accumulator dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_sat  (out_sat),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Compares one value and logs a failure line on mismatch.
   task automatic checkOutput(input string name, input logic [8:0] actual,
                              input logic [8:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Advances to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: the handshake happens on the rising edge, so sampling on the
   // falling edge sees out_valid/out_ready exactly as the DUT will.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected result", {out_sat, out_data}, 9'h000);
            if ({out_sat, out_data} === 9'h000) begin
               errors++;
               $display("[TB] FAIL unexpected result: got valid output expected none");
            end
         end else begin
            checkOutput("result {sat,data}", {out_sat, out_data}, expQ.pop_front());
         end
      end
   end

   // One evaluation: start pulse, three terms separated by 'gap' idle cycles
   // (with a stray start in the first gap), 'hold' cycles of back-pressure
   // in DONE with a stray start, then a handshake that also carries a start.
   task automatic applyStimulus(input logic [7:0] t0, input logic [7:0] t1,
                                input logic [7:0] t2, input int gap,
                                input int hold, input logic [7:0] expData,
                                input logic expSat);
      logic [7:0] terms[3];
      logic [7:0] heldData;
      logic       heldSat;
      terms[0] = t0;
      terms[1] = t1;
      terms[2] = t2;
      expQ.push_back({expSat, expData});
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("in_ready in ACCUM", {8'd0, in_ready}, 9'd1);
      checkOutput("busy in ACCUM", {8'd0, busy}, 9'd1);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = terms[i];
         tick();
         in_valid = 1'b0;
         in_data  = 8'h00;
         if (i < 2) begin
            for (int g = 0; g < gap; g++) begin
               if (g == 1) start = 1'b1;
               tick();
               start = 1'b0;
               checkOutput("no early out_valid", {8'd0, out_valid}, 9'd0);
            end
         end
      end
      checkOutput("out_valid latency", {8'd0, out_valid}, 9'd1);
      checkOutput("in_ready low in DONE", {8'd0, in_ready}, 9'd0);
      heldData = out_data;
      heldSat  = out_sat;
      for (int h = 0; h < hold; h++) begin
         if (h == 2) start = 1'b1;
         tick();
         start = 1'b0;
         checkOutput("held out_valid", {8'd0, out_valid}, 9'd1);
         checkOutput("held {sat,data}", {out_sat, out_data}, {heldSat, heldData});
      end
      out_ready = 1'b1;
      start     = 1'b1;
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
      checkOutput("out_valid after handshake", {8'd0, out_valid}, 9'd0);
      checkOutput("busy after handshake", {8'd0, busy}, 9'd0);
      tick();
      checkOutput("start at handshake ignored", {7'd0, busy, in_ready}, 9'd0);
   endtask

   // Drives reset and checks every output against its reset value.
   task automatic checkResetState(input string tag);
      checkOutput({tag, " in_ready"}, {8'd0, in_ready}, 9'd0);
      checkOutput({tag, " out_valid"}, {8'd0, out_valid}, 9'd0);
      checkOutput({tag, " out_data/sat"}, {out_sat, out_data}, 9'h000);
      checkOutput({tag, " busy"}, {8'd0, busy}, 9'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      #2;
      checkResetState("reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      checkResetState("post-reset");

      // Main vectors
      applyStimulus(8'h33, 8'h4B, 8'h0A, 0, 0, 8'h7F, 1'b1);
      applyStimulus(8'hB5, 8'hAA, 8'h0A, 0, 0, 8'hD5, 1'b0);
      applyStimulus(8'h81, 8'h01, 8'h80, 0, 0, 8'h00, 1'b0);
      applyStimulus(8'hFF, 8'hFF, 8'h8B, 0, 0, 8'hFF, 1'b1);
      // Saturation boundaries: +127, -127 exact, +128
      applyStimulus(8'h7F, 8'h00, 8'h00, 0, 0, 8'h7F, 1'b0);
      applyStimulus(8'hFF, 8'h80, 8'h80, 0, 0, 8'hFF, 1'b0);
      applyStimulus(8'h7F, 8'h01, 8'h00, 0, 0, 8'h7F, 1'b1);
      // Bubbles between terms and back-pressure in DONE
      applyStimulus(8'h14, 8'h92, 8'h03, 3, 5, 8'h05, 1'b0);

      // Reset mid-evaluation after two terms
      start = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h40;
      tick();
      in_data = 8'h30;
      tick();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #2;
      checkResetState("async reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      checkResetState("after abort");
      applyStimulus(8'h05, 8'h05, 8'h05, 0, 0, 8'h0F, 1'b0);

      tick();
      checkOutput("scoreboard drained", 9'(expQ.size()), 9'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/neuron_accumulator.md
Name: neuron_accumulator

Overview:
Sequential consumer of the neuron's 8-bit sign-magnitude term stream, such as weighted products from the datapath. It sums exactly N_TERMS terms per neuron evaluation in a wide two's-complement accumulator. It then returns one saturated 8-bit sign-magnitude result through a valid/ready output. It is the multi-cycle counterpart of the combinational adder and sits between the product stage and the activation stage.

Parameters:
N_TERMS, 3, number of terms summed per evaluation (>=1)
ACC_W, 12, internal two's-complement accumulator width; must satisfy 2^(ACC_W-1)-1 >= N_TERMS*127
CNT_W, 4, term counter width; must satisfy 2^CNT_W >= N_TERMS

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins an evaluation; honoured only in IDLE
in_valid  in  1  in_data carries a term
in_ready  out  1  block accepts a term this cycle
in_data  in  8  term: bit7 = sign (1 = negative), bits6:0 = magnitude
out_valid  out  1  result available
out_ready  in  1  downstream accepts the result
out_data  out  8  result in sign-magnitude format
out_sat  out  1  result was clamped; qualified by out_valid
busy  out  1  high in ACCUM and DONE

Behaviour:
- Reset is asynchronous and active-low on rst_n with one clock clk. While rst_n=0 and after release: state=IDLE, acc=0, cnt=0, in_ready=0, out_valid=0, out_data=8'h00, out_sat=0, busy=0.
- A reset asserted mid-evaluation aborts the evaluation. No partial result is ever emitted.
- FSM states are IDLE, ACCUM and DONE.
- IDLE: in_ready=0. On start, clear acc and cnt, then go to ACCUM on the next edge. start in ACCUM or DONE is ignored.
- ACCUM: in_ready=1. A term is accepted when in_valid and in_ready are both 1.
  - Conversion to two's complement: value = +mag if sign=0, -mag if sign=1. -0 (8'h80) converts to 0.
  - acc <= acc + value, sign-extended to ACC_W. No overflow is possible given the ACC_W rule.
  - Idle cycles (in_valid=0) leave acc and cnt unchanged.
  - When the accepted term has cnt==N_TERMS-1, register the converted result into out_data/out_sat and go to DONE.
- DONE: out_valid=1. out_data and out_sat are held stable while out_ready=0. When out_valid and out_ready are both 1, go to IDLE and out_valid falls the next cycle.
- Latency: out_valid rises on the first edge after the edge that accepted the last term, i.e. one cycle. Minimum evaluation takes 1 + N_TERMS + 1 cycles with no bubbles.
- Back-to-back evaluations: a start in the same cycle as the output handshake is ignored, because state is still DONE. start must come in IDLE.
- Output conversion from acc:
  - acc > 127: out_data = 8'h7F, out_sat = 1.
  - acc < -127: out_data = 8'hFF, out_sat = 1.
  - otherwise: sign = acc<0, magnitude = |acc|, out_sat = 0.
  - A zero result is always 8'h00, never 8'h80.

Decomposition:
- Shared package neuron_pkg holds:
  - SM_W = 8 and MAG_MAX = 7'd127;
  - the state enum {IDLE, ACCUM, DONE};
  - functions sm_to_tc (with ACC_W as an argument width) and tc_to_sm_sat, reusable by other neuron stages.
- One sub-module, sm_sat_convert: combinational acc -> {out_data, out_sat} clamp/convert, unit-testable on its own.
- The FSM, counter and accumulator stay in neuron_accumulator.

Test Plan:
- Terms 8'h33, 8'h4B, 8'h0A after start (+51+75+10 = 136) -> out_data = 8'h7F, out_sat = 1, out_valid one cycle after the third accept.
- Terms 8'hB5, 8'hAA, 8'h0A (-53-42+10 = -85) -> out_data = 8'hD5, out_sat = 0.
- Terms 8'h81, 8'h01, 8'h80 (-1+1-0) -> out_data = 8'h00 (not 8'h80), out_sat = 0.
- Terms 8'hFF, 8'hFF, 8'h8B (-265) -> out_data = 8'hFF, out_sat = 1.
- Stimulus: in_valid low for 3 cycles between terms, and out_ready held low 5 cycles in DONE with start pulsed meanwhile. Required response: acc/cnt unchanged during the gaps; out_data held stable; start ignored; return to IDLE only on the out_ready handshake.
- Stimulus: rst_n pulled low after 2 of 3 terms, then a new start with 8'h05, 8'h05, 8'h05. Required response: outputs at reset values immediately with no result emitted; next result = 8'h0F, out_sat = 0.
